// File: rtl/layer1_relu_stage.sv
// rtl/layer1_relu_stage.sv - Layer 1 to Layer 2 ReLU stage: capture, rescale, rectify, saturate, publish
module layer1_relu_stage #(
    parameter int NODES     = 20,
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 8,
    parameter int IDX_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inputsReady,
    input  logic [NODES*IN_WIDTH-1:0]     sumIn,
    output logic                          inputsRecieved,
    output logic                          outputsReady,
    input  logic                          outputsRecieved,
    output logic [NODES*OUT_WIDTH-1:0]    reluOutput,
    output logic [IDX_WIDTH:0]            nonZeroCount,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, PROCESS, PUBLISH} state_t;

    state_t                         state_q, state_d;
    logic [NODES*IN_WIDTH-1:0]      cap_q, cap_d;
    logic [NODES*OUT_WIDTH-1:0]     work_q, work_d;
    logic [NODES*OUT_WIDTH-1:0]     relu_q, relu_d;
    logic [IDX_WIDTH-1:0]           idx_q, idx_d;
    logic [IDX_WIDTH:0]             cnt_q, cnt_d;
    logic [IDX_WIDTH:0]             nz_q, nz_d;
    logic                           in_ack_q, in_ack_d;
    logic                           out_rdy_q, out_rdy_d;

    logic [IN_WIDTH-1:0]            cur_sum;
    logic signed [IN_WIDTH-1:0]     shifted;
    logic [OUT_WIDTH-1:0]           relu_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cap_q     <= '0;
            work_q    <= '0;
            relu_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            nz_q      <= '0;
            in_ack_q  <= 1'b0;
            out_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            work_q    <= work_d;
            relu_q    <= relu_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            nz_q      <= nz_d;
            in_ack_q  <= in_ack_d;
            out_rdy_q <= out_rdy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        work_d    = work_q;
        relu_d    = relu_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        nz_d      = nz_q;
        in_ack_d  = in_ack_q;
        out_rdy_d = out_rdy_q;

        cur_sum = '0;
        for (int i = 0; i < NODES; i++) begin
            if (idx_q == IDX_WIDTH'(i)) cur_sum = cap_q[i*IN_WIDTH +: IN_WIDTH];
        end
        shifted = $signed(cur_sum) >>> SHIFT;

        // Negative or zero rectifies to 0; anything above the output range saturates.
        if (shifted[IN_WIDTH-1] || (shifted == '0))
            relu_val = '0;
        else if (|shifted[IN_WIDTH-1:OUT_WIDTH])
            relu_val = '1;
        else
            relu_val = shifted[OUT_WIDTH-1:0];

        if (in_ack_q && !inputsReady)      in_ack_d  = 1'b0;
        if (out_rdy_q && outputsRecieved)  out_rdy_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (inputsReady && !in_ack_q) begin
                    cap_d    = sumIn;
                    idx_d    = '0;
                    cnt_d    = '0;
                    in_ack_d = 1'b1;
                    state_d  = PROCESS;
                end
            end
            PROCESS: begin
                for (int i = 0; i < NODES; i++) begin
                    if (idx_q == IDX_WIDTH'(i)) work_d[i*OUT_WIDTH +: OUT_WIDTH] = relu_val;
                end
                if (relu_val != '0) cnt_d = cnt_q + (IDX_WIDTH+1)'(1);
                if (idx_q == IDX_WIDTH'(NODES-1))
                    state_d = PUBLISH;
                else
                    idx_d = idx_q + IDX_WIDTH'(1);
            end
            PUBLISH: begin
                // Publishing only with ready and ack both low keeps it disjoint from the ack clear.
                if (!out_rdy_q && !outputsRecieved) begin
                    relu_d    = work_q;
                    nz_d      = cnt_q;
                    out_rdy_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inputsRecieved = in_ack_q;
    assign outputsReady   = out_rdy_q;
    assign reluOutput     = relu_q;
    assign nonZeroCount   = nz_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_layer1_relu_stage.sv
// tb/tb_layer1_relu_stage.sv - directed self-checking bench for layer1_relu_stage
module tb_layer1_relu_stage;

    localparam int NODES = 20;
    localparam int IW    = 24;
    localparam int OW    = 8;
    localparam int XW    = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 inputsReady;
    logic [NODES*IW-1:0]  sumIn;
    logic                 inputsRecieved;
    logic                 outputsReady;
    logic                 outputsRecieved;
    logic [NODES*OW-1:0]  reluOutput;
    logic [XW:0]          nonZeroCount;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [NODES*IW-1:0]  s;
    logic [NODES*OW-1:0]  ea, eb;

    layer1_relu_stage dut (
        .clk             (clk),
        .reset           (reset),
        .inputsReady     (inputsReady),
        .sumIn           (sumIn),
        .inputsRecieved  (inputsRecieved),
        .outputsReady    (outputsReady),
        .outputsRecieved (outputsRecieved),
        .reluOutput      (reluOutput),
        .nonZeroCount    (nonZeroCount),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_vector(input logic [NODES*IW-1:0] v);
        sumIn       = v;
        inputsReady = 1'b1;
        tick();
        check("capture_ack", 192'(inputsRecieved), 192'(1));
        inputsReady = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!outputsReady && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic ack_out();
        outputsRecieved = 1'b1;
        tick();
        check("ack_drop", 192'(outputsReady), 192'(0));
        outputsRecieved = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; inputsReady = 1'b1; outputsRecieved = 1'b0; sumIn = '1;
        // 1: reset with a stray inputsReady
        tick(); tick();
        check("rst_ack",  192'(inputsRecieved), 192'(0));
        check("rst_rdy",  192'(outputsReady),   192'(0));
        check("rst_relu", 192'(reluOutput),     192'(0));
        check("rst_nz",   192'(nonZeroCount),   192'(0));
        check("rst_busy", 192'(busy),           192'(0));
        inputsReady = 1'b0; reset = 1'b0;
        tick();
        check("post_rst_busy", 192'(busy), 192'(0));

        // 2: basic vector and latency
        s = '0;
        s[0*IW +: IW] = 24'h000300;
        s[1*IW +: IW] = 24'hFFFE00;
        s[2*IW +: IW] = 24'h010000;
        s[3*IW +: IW] = 24'h0000FF;
        ea = '0; ea[0*OW +: OW] = 8'd3; ea[2*OW +: OW] = 8'd255;
        send_vector(s);
        check("busy_proc", 192'(busy), 192'(1));
        wait_out(cyc);
        check("latency_a",  192'(cyc),          192'(21));
        check("relu_a",     192'(reluOutput),   192'(ea));
        check("nz_a",       192'(nonZeroCount), 192'(2));
        check("in_ack_rel", 192'(inputsRecieved), 192'(0));
        check("idle_a",     192'(busy),         192'(0));
        ack_out();

        // 3: boundaries, including the last node
        s = '0;
        s[0*IW +: IW]  = 24'hFFFFFF;
        s[1*IW +: IW]  = 24'h00FFFF;
        s[2*IW +: IW]  = 24'h7FFFFF;
        s[3*IW +: IW]  = 24'h800000;
        s[4*IW +: IW]  = 24'h000100;
        s[19*IW +: IW] = 24'h001234;
        ea = '0;
        ea[1*OW +: OW] = 8'd255; ea[2*OW +: OW] = 8'd255;
        ea[4*OW +: OW] = 8'd1;   ea[19*OW +: OW] = 8'h12;
        send_vector(s);
        wait_out(cyc);
        check("latency_bnd", 192'(cyc),          192'(21));
        check("relu_bnd",    192'(reluOutput),   192'(ea));
        check("nz_bnd",      192'(nonZeroCount), 192'(4));
        ack_out();

        // 4: backpressure - B processed while A is still held
        s = '0; s[5*IW +: IW] = 24'h000500;
        ea = '0; ea[5*OW +: OW] = 8'd5;
        send_vector(s);
        wait_out(cyc);
        check("latency_pa", 192'(cyc), 192'(21));
        s = '0; s[0*IW +: IW] = 24'h000100; s[6*IW +: IW] = 24'h000A00;
        eb = '0; eb[0*OW +: OW] = 8'd1; eb[6*OW +: OW] = 8'd10;
        send_vector(s);
        repeat (25) tick();
        check("bp_busy",  192'(busy),         192'(1));
        check("bp_rdy",   192'(outputsReady), 192'(1));
        check("bp_hold",  192'(reluOutput),   192'(ea));
        s = '1; sumIn = s; inputsReady = 1'b1;
        repeat (3) tick();
        check("bp_refuse", 192'(inputsRecieved), 192'(0));
        inputsReady = 1'b0;
        outputsRecieved = 1'b1;
        tick();
        check("bp_ack_drop", 192'(outputsReady), 192'(0));
        tick();
        check("bp_blocked", 192'(outputsReady), 192'(0));
        check("bp_still_a", 192'(reluOutput),   192'(ea));
        outputsRecieved = 1'b0;
        tick();
        check("bp_pub_b",  192'(outputsReady), 192'(1));
        check("bp_relu_b", 192'(reluOutput),   192'(eb));
        check("bp_nz_b",   192'(nonZeroCount), 192'(2));
        ack_out();

        // 5: upstream holds inputsReady for 40 cycles
        s = '0; s[2*IW +: IW] = 24'h002000;
        ea = '0; ea[2*OW +: OW] = 8'd32;
        sumIn = s; inputsReady = 1'b1;
        repeat (20) tick();
        check("hold_ack20", 192'(inputsRecieved), 192'(1));
        sumIn = '1;
        repeat (20) tick();
        check("hold_ack40", 192'(inputsRecieved), 192'(1));
        check("hold_single", 192'(busy),          192'(0));
        check("hold_relu",  192'(reluOutput),     192'(ea));
        check("hold_nz",    192'(nonZeroCount),   192'(1));
        inputsReady = 1'b0;
        tick();
        check("hold_release", 192'(inputsRecieved), 192'(0));
        ack_out();

        // 6: reset while processing index 7
        s = '0; s[3*IW +: IW] = 24'h000900;
        send_vector(s);
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 192'(busy),           192'(0));
        check("mid_rst_ack",  192'(inputsRecieved), 192'(0));
        check("mid_rst_relu", 192'(reluOutput),     192'(0));
        check("mid_rst_nz",   192'(nonZeroCount),   192'(0));
        tick();
        check("mid_rst_rdy",  192'(outputsReady),   192'(0));
        s = '0; s[10*IW +: IW] = 24'h000700; s[19*IW +: IW] = 24'h00FF00;
        ea = '0; ea[10*OW +: OW] = 8'd7; ea[19*OW +: OW] = 8'd255;
        send_vector(s);
        wait_out(cyc);
        check("latency_f", 192'(cyc),          192'(21));
        check("relu_f",    192'(reluOutput),   192'(ea));
        check("nz_f",      192'(nonZeroCount), 192'(2));
        ack_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
